// File: rtl/adder_pkg.sv
// Shared FSM encoding and counter-width helper for the serial chunk adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n chunks; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// CHUNK-bit ripple adder built from full-adder cells; combinational, no flow control.
// c_msb is the carry into the top bit, needed for signed overflow.
module chunk_ripple_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    one_bit_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .sum  (sum[i]),
      .c_out(c[i+1])
    );
  end

  assign c_out = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/one_bit_adder.sv
// Full adder cell: combinational, zero latency, no flow control.
module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per cycle; done follows accepted start by WIDTH/CHUNK cycles.
// start is ignored while busy; SERIAL_ADDER_SUBTRACT_EN adds a sub input for a - b.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_chunk_adder: CHUNK must divide WIDTH exactly");
  end

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_co, chunk_cmsb;
  logic             last;

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (last) state_nxt = DONE;
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Operands shift right each cycle so the active chunk is always in the low bits.
  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .c_in (carry),
    .sum  (chunk_sum),
    .c_out(chunk_co),
    .c_msb(chunk_cmsb)
  );

  // Result fills from the top; after NCHUNK shifts chunk 0 lands in the low bits.
  if (CHUNK == WIDTH) begin : g_sum_full
    assign sum_nxt = chunk_sum;
  end else begin : g_sum_shift
    assign sum_nxt = {chunk_sum, sum[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
      b_q      <= sub ? ~b : b;
      carry    <= sub ? 1'b1 : c_in;
`else
      b_q      <= b;
      carry    <= c_in;
`endif
    end else if (state == RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      carry <= chunk_co;
      cnt   <= cnt + CW'(1);
      sum   <= sum_nxt;
      if (last) begin
        c_out    <= chunk_co;
        overflow <= chunk_co ^ chunk_cmsb;
      end
    end
  end

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using a registered carry between chunks. It is the sequential successor of the team's one-bit full adder: the same carry-ripple arithmetic, generalised in width, and time-multiplexed over a single chunk datapath. It sits behind a start/busy/done handshake so a controller can trade area for latency by choosing CHUNK.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
CHUNK, 1, bits added per cycle; must divide WIDTH exactly (elaboration error otherwise).
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a new addition; sampled only when accepted (see Behaviour)
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
c_in  input  1  carry-in; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result; holds its value until the next accepted start
c_out  output  1  carry out of bit WIDTH-1
overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- States: IDLE, RUN, DONE. Reset value of every output is 0; state = IDLE; chunk counter = 0; internal carry = 0.
- Start acceptance: start=1 in IDLE or DONE -> capture a, b, c_in into internal registers; clear sum; counter=0; carry=c_in; next state RUN. start=1 in RUN is ignored (no effect on the operation in flight).
- RUN: each cycle adds chunk i (bits i*CHUNK .. i*CHUNK+CHUNK-1) of the captured operands plus the carry register; writes those bits of sum and updates the carry register; counter increments. On the cycle processing chunk NCHUNK-1: c_out and overflow are registered, and next state is DONE.
- Latency: if start is accepted at edge k, done is high in the cycle following edge k+NCHUNK (for WIDTH=8, CHUNK=1: 8 cycles; for CHUNK=WIDTH: 1 cycle).
- busy = 1 exactly while the state is RUN. done = 1 exactly while the state is DONE (one cycle). DONE -> IDLE unless start is accepted in DONE (then -> RUN; done is still high for that cycle).
- sum, c_out and overflow are stable from DONE until the next accepted start. Partial sum bits are visible during RUN; they must not be relied on.
- Arithmetic is unsigned modulo 2^WIDTH; c_out is the WIDTH+1'th bit. overflow is valid in two's-complement interpretation.
- Reset mid-operation: the operation is aborted, no done pulse occurs, and all outputs return to 0 on the next edge. rst has priority over start.
- Operand changes on a/b/c_in after capture have no effect.

Optional Feature:
Macro SERIAL_ADDER_SUBTRACT_EN. When defined: an extra input port sub (1 bit) is captured with start; sub=1 computes a - b by capturing ~b and forcing the initial carry to 1 (c_in ignored); c_out = 1 means no borrow; overflow is signed subtraction overflow. When undefined: the sub port does not exist and the block only adds.

Decomposition:
- Shared package/include adder_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a width helper for the counter, $clog2(NCHUNK) with a minimum of 1.
- One sub-module: chunk_ripple_adder #(CHUNK) — purely combinational CHUNK-bit ripple built from one_bit_adder instances, with outputs sum, carry out, and carry into its MSB (used for overflow).

Test Plan:
- WIDTH=8, CHUNK=1: a=8'hFF, b=8'h01, c_in=0, start pulse -> done exactly 8 cycles later, sum=8'h00, c_out=1, overflow=0; busy high for 8 cycles.
- a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0, overflow=1; then a=8'h00, b=8'h00, c_in=1 -> sum=8'h01, c_out=0.
- While busy: a second start with a=8'h11, b=8'h22 -> ignored; the first result is unchanged and there is exactly one done pulse.
- rst=1 at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, c_out=0; no done follows; a new start afterwards completes normally.
- WIDTH=8, CHUNK=4: a=8'hA5, b=8'h5B -> done after 2 cycles, sum=8'h00, c_out=1. Back-to-back start during the DONE cycle is accepted.
- SERIAL_ADDER_SUBTRACT_EN defined, sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, c_out=0, overflow=0; a=8'h80, b=8'h01 -> sum=8'h7F, overflow=1.
